// File: rtl/conv_host_mem.sv
// Target side of the CONV accelerator port: loads the input image from a host stream,
// serves image fetches and layer-0/1 memory traffic, then streams both result banks out.
module conv_host_mem #(
   parameter int IMG_WORDS   = 4096,
   parameter int L1_WORDS    = 1024,
   parameter int ARM_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        load_valid,
   input  logic [19:0] load_data,
   output logic        load_ready,
   input  logic        busy,
   output logic        ready,
   input  logic [11:0] iaddr,
   output logic [19:0] idata,
   input  logic        cwr,
   input  logic [11:0] caddr_wr,
   input  logic [19:0] cdata_wr,
   input  logic        crd,
   input  logic [11:0] caddr_rd,
   output logic [19:0] cdata_rd,
   input  logic [2:0]  csel,
   output logic        dump_valid,
   output logic [19:0] dump_data,
   output logic        dump_last,
   input  logic        dump_ready,
   output logic        done,
   output logic [2:0]  err
);

   localparam int L1_AW = $clog2(L1_WORDS);
   localparam int TO_W  = $clog2(ARM_TIMEOUT);
   localparam logic [11:0]     LOAD_LAST = 12'(IMG_WORDS - 1);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(ARM_TIMEOUT - 1);
   localparam logic [12:0]     DUMP_LAST = 13'(IMG_WORDS + L1_WORDS - 1);
   localparam logic [12:0]     L1_BASE   = 13'(IMG_WORDS);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_DUMP, S_DONE} state_t;

   state_t            state, state_nx;
   logic [11:0]       lcnt, lcnt_nx;
   logic [TO_W-1:0]   tcnt, tcnt_nx;
   logic [12:0]       dcnt, dcnt_nx;
   logic [2:0]        err_nx;
   logic [19:0]       rd_hold;

   logic [19:0] img [IMG_WORDS];
   logic [19:0] l0  [IMG_WORDS];
   logic [19:0] l1  [L1_WORDS];

   logic active, sel_l0, sel_l1, l1_wr_ok, rd_ok;
   logic wr_l0, wr_l1, wr_bad_csel, wr_bad_addr, rd_bad_csel;

   assign active      = (state == S_ARM) || (state == S_RUN);
   assign sel_l0      = (csel == 3'b001);
   assign sel_l1      = (csel == 3'b011);
   assign l1_wr_ok    = (caddr_wr[11:L1_AW] == '0);
   assign rd_ok       = crd && (sel_l0 || sel_l1);
   assign wr_l0       = active && cwr && sel_l0;
   assign wr_l1       = active && cwr && sel_l1 && l1_wr_ok;
   assign wr_bad_addr = active && cwr && sel_l1 && !l1_wr_ok;
   assign wr_bad_csel = active && cwr && !sel_l0 && !sel_l1;
   assign rd_bad_csel = crd && !sel_l0 && !sel_l1;

   assign load_ready = (state == S_LOAD);
   assign ready      = (state == S_ARM);
   assign done       = (state == S_DONE);
   assign dump_valid = (state == S_DUMP);
   assign dump_last  = (state == S_DUMP) && (dcnt == DUMP_LAST);
   assign idata      = active ? img[iaddr] : '0;

   // Read data is live while a valid read is strobed, otherwise the last captured word.
   assign cdata_rd = rd_ok ? (sel_l0 ? l0[caddr_rd] : l1[caddr_rd[L1_AW-1:0]]) : rd_hold;

   // L1 occupies the dump stream after L0; IMG_WORDS is a multiple of L1_WORDS, so the
   // low dcnt bits index L1 directly.
   always_comb begin
      dump_data = '0;
      if (state == S_DUMP) begin
         if (dcnt < L1_BASE) dump_data = l0[dcnt[11:0]];
         else                dump_data = l1[dcnt[L1_AW-1:0]];
      end
   end

   always_comb begin
      state_nx = state;
      lcnt_nx  = lcnt;
      tcnt_nx  = tcnt;
      dcnt_nx  = dcnt;
      err_nx   = err;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nx = S_LOAD;
               lcnt_nx  = '0;
               err_nx   = '0;
            end
         end
         S_LOAD: begin
            if (load_valid) begin
               lcnt_nx = lcnt + 12'd1;
               if (lcnt == LOAD_LAST) begin
                  state_nx = S_ARM;
                  tcnt_nx  = '0;
               end
            end
         end
         S_ARM: begin
            if (busy) begin
               state_nx = S_RUN;
            end else if (tcnt == TO_LAST) begin
               state_nx  = S_DONE;
               err_nx[2] = 1'b1;
            end else begin
               tcnt_nx = tcnt + 1'b1;
            end
         end
         S_RUN: begin
            if (!busy) begin
               state_nx = S_DUMP;
               dcnt_nx  = '0;
            end
         end
         S_DUMP: begin
            if (dump_ready) begin
               if (dcnt == DUMP_LAST) begin
                  state_nx = S_DONE;
                  dcnt_nx  = '0;
               end else begin
                  dcnt_nx = dcnt + 13'd1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
      err_nx[1] = err_nx[1] | wr_bad_csel | rd_bad_csel;
      err_nx[0] = err_nx[0] | wr_bad_addr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         lcnt    <= '0;
         tcnt    <= '0;
         dcnt    <= '0;
         err     <= '0;
         rd_hold <= '0;
      end else begin
         state <= state_nx;
         lcnt  <= lcnt_nx;
         tcnt  <= tcnt_nx;
         dcnt  <= dcnt_nx;
         err   <= err_nx;
         if (crd) rd_hold <= cdata_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_LOAD && load_valid) img[lcnt] <= load_data;
      if (wr_l0) l0[caddr_wr] <= cdata_wr;
      if (wr_l1) l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
   end

endmodule
